// File: rtl/aes_table_gen.sv
// aes_table_gen: sequential writer that generates the AES constant tables
// (SBox, IBox, EXP3, LN3, RCon) and streams each entry as one valid/ready
// write beat. Optional build macro AES_TABLE_GEN_STALL_EN adds a saturating
// stall-cycle counter output (stall_cnt).
module aes_table_gen #(
   parameter int unsigned RC_N  = 16,
   parameter int unsigned SEL_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             wr_valid,
   input  logic             wr_ready,
   output logic [SEL_W-1:0] wr_sel,
   output logic [7:0]       wr_addr,
`ifdef AES_TABLE_GEN_STALL_EN
   output logic [15:0]      stall_cnt,
`endif
   output logic [7:0]       wr_data
);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StExpW = 3'd1;
   localparam logic [2:0] StLnW  = 3'd2;
   localparam logic [2:0] StSbW  = 3'd3;
   localparam logic [2:0] StIbW  = 3'd4;
   localparam logic [2:0] StRcW  = 3'd5;
   localparam logic [2:0] StDone = 3'd6;

   localparam logic [7:0] RcLast = 8'(RC_N - 1);

   logic [2:0] state_q, state_d;
   logic [7:0] i_q, i_d;   // table index; also RCon index j
   logic [7:0] x_q, x_d;   // running power of 3; also RCon value r
   logic [7:0] s_q, s_d;   // SBox value carried into the IBox beat

   logic [7:0] exp_mem [256];
   logic [7:0] ln_mem  [256];

   logic [7:0] inv_idx, inv, sbox_val;
   logic       accept;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   // Multiplicative inverse via log/exp tables, then the AES affine map.
   always_comb begin
      inv_idx  = 8'hFF - ln_mem[i_q];
      inv      = (i_q == 8'h00) ? 8'h00 : exp_mem[inv_idx];
      sbox_val = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

   // Beat contents are a pure function of state, so they hold while stalled.
   always_comb begin
      wr_valid = 1'b0;
      wr_sel   = '0;
      wr_addr  = 8'h00;
      wr_data  = 8'h00;
      unique case (state_q)
         StExpW: begin
            wr_valid = 1'b1;
            wr_sel   = SEL_W'(2);
            wr_addr  = i_q;
            wr_data  = x_q;
         end
         StLnW: begin
            wr_valid = 1'b1;
            wr_sel   = SEL_W'(3);
            // LN3[0] is defined as 0; the last step would otherwise rewrite LN3[1].
            if (i_q != 8'hFF) begin
               wr_addr = x_q;
               wr_data = i_q;
            end
         end
         StSbW: begin
            wr_valid = 1'b1;
            wr_sel   = SEL_W'(0);
            wr_addr  = i_q;
            wr_data  = sbox_val;
         end
         StIbW: begin
            wr_valid = 1'b1;
            wr_sel   = SEL_W'(1);
            wr_addr  = s_q;
            wr_data  = i_q;
         end
         StRcW: begin
            wr_valid = 1'b1;
            wr_sel   = SEL_W'(4);
            wr_addr  = i_q;
            wr_data  = x_q;
         end
         default: ;
      endcase
      busy   = (state_q != StIdle);
      done   = (state_q == StDone);
      accept = wr_valid && wr_ready;
   end

   // Next-state logic for the generator sequence.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      x_d     = x_q;
      s_d     = s_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StExpW;
               i_d     = 8'h00;
               x_d     = 8'h01;
            end
         end
         StExpW: if (accept) state_d = StLnW;
         StLnW: begin
            if (accept) begin
               x_d     = x_q ^ xtime(x_q);
               i_d     = i_q + 8'd1;
               state_d = (i_q == 8'hFF) ? StSbW : StExpW;
            end
         end
         StSbW: begin
            if (accept) begin
               s_d     = sbox_val;
               state_d = StIbW;
            end
         end
         StIbW: begin
            if (accept) begin
               i_d = i_q + 8'd1;
               if (i_q == 8'hFF) begin
                  state_d = StRcW;
                  x_d     = 8'h00;
               end else begin
                  state_d = StSbW;
               end
            end
         end
         StRcW: begin
            if (accept) begin
               i_d     = i_q + 8'd1;
               x_d     = (i_q == 8'h00) ? 8'h01 : xtime(x_q);
               state_d = (i_q == RcLast) ? StDone : StRcW;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         i_q     <= 8'h00;
         x_q     <= 8'h00;
         s_q     <= 8'h00;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         x_q     <= x_d;
         s_q     <= s_d;
      end
   end

   // Log/exp storage filled during the EXP/LN phase; contents need no reset.
   always_ff @(posedge clock) begin
      if (state_q == StExpW) exp_mem[i_q] <= x_q;
      if (state_q == StLnW && i_q != 8'hFF) ln_mem[x_q] <= i_q;
   end

`ifdef AES_TABLE_GEN_STALL_EN
   // Count busy cycles where a beat waits on the downstream, saturating.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt <= 16'h0000;
      end else if (state_q == StIdle && start) begin
         stall_cnt <= 16'h0000;
      end else if (busy && wr_valid && !wr_ready && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`else
   // No stall counter in this build.
`endif

endmodule

// File: tb/tb_aes_table_gen.sv
// tb_aes_table_gen: directed bench for aes_table_gen. Captures every write
// beat, compares the stream against a software AES reference model and
// against hand-computed table entries. Honors AES_TABLE_GEN_STALL_EN.
module tb_aes_table_gen;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, wr_valid;
   logic       wr_ready = 1'b1;
   logic [2:0] wr_sel;
   logic [7:0] wr_addr, wr_data;
`ifdef AES_TABLE_GEN_STALL_EN
   logic [15:0] stall_cnt;
`endif

   aes_table_gen #(.RC_N(16), .SEL_W(3)) dut (
`ifdef AES_TABLE_GEN_STALL_EN
      .stall_cnt(stall_cnt),
`endif
      .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
      .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // Model and capture state
   logic [7:0]  m_exp [256];
   logic [7:0]  m_ln  [256];
   logic [7:0]  m_sbox [256];
   logic [18:0] exp_stream [1040];
   logic [18:0] cap_beat [1100];
   logic [7:0]  cap_tab [5][256];
   int          beat_n = 0;
   int          done_cnt = 0;
   int          stall_seen = 0;
   bit          rand_mode = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_beat = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p  = 8'h00;
      logic [7:0] aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p ^= aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   // Ready driver: full speed or 50% random.
   initial forever begin
      @(posedge clock);
      #1;
      wr_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor sampled mid-cycle: beat capture, stall stability, done/stall counts.
   initial forever begin
      @(negedge clock);
      if (prev_stall)
         check("stall_hold", {12'h0, wr_valid, wr_sel, wr_addr, wr_data}, prev_beat);
      prev_stall = wr_valid && !wr_ready && !reset;
      prev_beat  = {12'h0, wr_valid, wr_sel, wr_addr, wr_data};
      if (wr_valid && wr_ready && !reset) begin
         if (beat_n < 1100) cap_beat[beat_n] = {wr_sel, wr_addr, wr_data};
         if (wr_sel < 3'd5) cap_tab[wr_sel][wr_addr] = wr_data;
         beat_n++;
      end
      if (done) done_cnt++;
      if (busy && wr_valid && !wr_ready && !reset) stall_seen++;
   end

   task automatic build_model();
      logic [7:0] e, r, inv, s;
      int n;
      e = 8'h01;
      for (int i = 0; i < 256; i++) begin
         m_exp[i] = e;
         e = gmul(e, 8'h03);
      end
      m_ln[0] = 8'h00;
      for (int i = 0; i < 255; i++) m_ln[m_exp[i]] = 8'(i);
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         m_sbox[x] = s;
      end
      n = 0;
      for (int i = 0; i < 256; i++) begin
         exp_stream[n] = {3'd2, 8'(i), m_exp[i]};
         n++;
         exp_stream[n] = (i < 255) ? {3'd3, m_exp[i], 8'(i)} : {3'd3, 8'h00, 8'h00};
         n++;
      end
      for (int i = 0; i < 256; i++) begin
         exp_stream[n] = {3'd0, 8'(i), m_sbox[i]};
         n++;
         exp_stream[n] = {3'd1, m_sbox[i], 8'(i)};
         n++;
      end
      r = 8'h00;
      for (int j = 0; j < 16; j++) begin
         exp_stream[n] = {3'd4, 8'(j), r};
         n++;
         r = (j == 0) ? 8'h01 : gmul(r, 8'h02);
      end
   endtask

   // Drive start for one cycle from now; return edges until done is seen.
   // busy_pulse_at >= 0 also pulses start once when that many beats are done.
   task automatic do_run(input int busy_pulse_at, output int edges);
      bit pulsed = 1'b0;
      beat_n     = 0;
      done_cnt   = 0;
      stall_seen = 0;
      edges      = 0;
      start      = 1'b1;
      while (edges < 10000) begin
         @(posedge clock);
         #1;
         start = 1'b0;
         edges++;
         if (done) break;
         if (busy_pulse_at >= 0 && !pulsed && beat_n >= busy_pulse_at) begin
            start  = 1'b1;
            pulsed = 1'b1;
         end
      end
      check("done_seen", {31'h0, done}, 32'h1);
   endtask

   task automatic check_stream(input string tag);
      for (int n = 0; n < 1040; n++)
         check(tag, {13'h0, cap_beat[n]}, {13'h0, exp_stream[n]});
   endtask

   int edges;
   int beats_at;

   initial begin
      build_model();

      // Reset state
      @(posedge clock);
      #1;
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_valid", {31'h0, wr_valid}, 32'h0);
      check("rst_beat", {13'h0, wr_sel, wr_addr, wr_data}, 32'h0);
      // Start together with reset: reset wins
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      check("rst_start_busy", {31'h0, busy}, 32'h0);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Run 1: full speed; done in the 1042nd cycle counting the start cycle
      do_run(-1, edges);
      check("lat_edges", edges, 32'd1041);
      check("beats_r1", beat_n, 32'd1040);
      check("beat0", {13'h0, cap_beat[0]}, {13'h0, 3'd2, 8'h00, 8'h01});
      check("beat1", {13'h0, cap_beat[1]}, {13'h0, 3'd3, 8'h01, 8'h00});
      check("beat2", {13'h0, cap_beat[2]}, {13'h0, 3'd2, 8'h01, 8'h03});
      check("beat3", {13'h0, cap_beat[3]}, {13'h0, 3'd3, 8'h03, 8'h01});
      check_stream("stream_r1");
      check("sbox_00", {24'h0, cap_tab[0][8'h00]}, 32'h63);
      check("sbox_53", {24'h0, cap_tab[0][8'h53]}, 32'hED);
      check("sbox_ff", {24'h0, cap_tab[0][8'hFF]}, 32'h16);
      check("ibox_63", {24'h0, cap_tab[1][8'h63]}, 32'h00);
      check("ibox_16", {24'h0, cap_tab[1][8'h16]}, 32'hFF);
      check("exp3_ff", {24'h0, cap_tab[2][8'hFF]}, 32'h01);
      check("ln3_00", {24'h0, cap_tab[3][8'h00]}, 32'h00);
      check("ln3_03", {24'h0, cap_tab[3][8'h03]}, 32'h01);
      check("ln3_ff", {24'h0, cap_tab[3][8'hFF]}, 32'h07);
      check("rcon_9", {24'h0, cap_tab[4][8'h09]}, 32'h1B);
      check("rcon_15", {24'h0, cap_tab[4][8'h0F]}, 32'h9A);
`ifdef AES_TABLE_GEN_STALL_EN
      check("stall_r1", {16'h0, stall_cnt}, 32'h0);
`endif
      @(posedge clock);
      #1;
      check("idle_after_r1", {30'h0, busy, done}, 32'h0);

      // Run 2: random ready, start pulsed while busy and in the done cycle
      rand_mode = 1'b1;
      do_run(100, edges);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      rand_mode = 1'b0;
      check("done_start_busy", {31'h0, busy}, 32'h0);
      check("beats_r2", beat_n, 32'd1040);
      check("done_cnt_r2", done_cnt, 32'd1);
      check_stream("stream_r2");
`ifdef AES_TABLE_GEN_STALL_EN
      check("stall_r2", {16'h0, stall_cnt}, stall_seen);
`endif
      repeat (3) @(posedge clock);
      #1;
      check("beats_r2_after", beat_n, 32'd1040);
      check("idle_r2_after", {31'h0, busy}, 32'h0);

      // Run 3: reset asserted at beat 300
      beat_n   = 0;
      done_cnt = 0;
      start    = 1'b1;
      edges    = 0;
      @(posedge clock);
      #1;
      start = 1'b0;
      while (beat_n < 300 && edges < 2000) begin
         @(posedge clock);
         #1;
         edges++;
      end
      check("reach_300", {31'h0, 1'(beat_n >= 300)}, 32'h1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("abort_valid", {31'h0, wr_valid}, 32'h0);
      check("abort_busy", {31'h0, busy}, 32'h0);
      beats_at = beat_n;
      repeat (5) @(posedge clock);
      #1;
      check("abort_beats", beat_n, beats_at);
      check("abort_done", done_cnt, 32'd0);

      // Run 4: fresh start after abort
      do_run(-1, edges);
      check("lat_r4", edges, 32'd1041);
      check("beats_r4", beat_n, 32'd1040);
      check_stream("stream_r4");

      // Run 5: start one cycle after done is accepted
      @(posedge clock);
      #1;
      check("idle_pre_r5", {31'h0, busy}, 32'h0);
      do_run(-1, edges);
      check("lat_r5", edges, 32'd1041);
      check("beats_r5", beat_n, 32'd1040);
      check("done_cnt_r5", done_cnt, 32'd0);
      check_stream("stream_r5");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
